// File: rtl/pe_mac.sv
// -----------------------------------------------------------------------------
// pe_mac : systolic-array processing element with a multiply-accumulate core.
//
// Purpose
//   Accumulates K products ifm_in*w_in, one per qualified beat, and presents
//   the sum on psum_out with a one-cycle psum_valid strobe. Operand pairs are
//   also forwarded, registered, to the neighbouring PE in every state.
//
// Configuration
//   PE_SATURATE_EN : when defined, each accumulation that leaves the ACC_W
//                    range clamps to the max/min representable value and sets
//                    the sticky ovf flag. When undefined the accumulator wraps
//                    modulo 2^ACC_W and ovf is tied to 0.
//
// Parameters
//   DATA_W  operand width (ifm and weight)
//   ACC_W   accumulator / psum width, ACC_W >= 2*DATA_W
//   LEN_W   width of the beat-count input len
//   SIGNED  1 = two's-complement operands, 0 = unsigned
//
// Ports
//   clk         in   1       sole clock, rising edge
//   rst         in   1       asynchronous active-high reset
//   start       in   1       one-cycle request to begin an accumulation
//   len         in   LEN_W   beat count K, sampled with start
//   abort       in   1       cancel the running accumulation, no result
//   ifm_in      in   DATA_W  feature-map operand
//   w_in        in   DATA_W  weight operand
//   in_valid    in   1       qualifies ifm_in / w_in
//   ifm_pass    out  DATA_W  registered copy of ifm_in
//   w_pass      out  DATA_W  registered copy of w_in
//   pass_valid  out  1       registered copy of in_valid
//   psum_out    out  ACC_W   accumulated result
//   psum_valid  out  1       result strobe, one cycle
//   busy        out  1       high while accumulating or presenting the result
//   ovf         out  1       sticky overflow flag (saturating build only)
// -----------------------------------------------------------------------------
module pe_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 8,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic [DATA_W-1:0] ifm_in,
  input  logic [DATA_W-1:0] w_in,
  input  logic              in_valid,
  output logic [DATA_W-1:0] ifm_pass,
  output logic [DATA_W-1:0] w_pass,
  output logic              pass_valid,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_valid,
  output logic              busy,
  output logic              ovf
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt;
  logic [LEN_W-1:0]    cnt_inc;
  logic [ACC_W-1:0]    acc;
  logic [2*DATA_W-1:0] ifm_ext;
  logic [2*DATA_W-1:0] w_ext;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    acc_next;
  logic                beat_accept;

  // Forward path to the neighbour PE: a plain one-cycle register stage that
  // runs regardless of the accumulation state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifm_pass   <= '0;
      w_pass     <= '0;
      pass_valid <= 1'b0;
    end else begin
      ifm_pass   <= ifm_in;
      w_pass     <= w_in;
      pass_valid <= in_valid;
    end
  end

  // Operands are widened to the product width first so that the low 2*DATA_W
  // bits of the multiply are correct for both signed and unsigned data. The
  // product is then extended to ACC_W by filling with its sign bit (signed)
  // or zeros (unsigned); this form avoids a zero-width replication when
  // ACC_W equals 2*DATA_W.
  always_comb begin
    ifm_ext = {{DATA_W{(SIGNED != 0) && ifm_in[DATA_W-1]}}, ifm_in};
    w_ext   = {{DATA_W{(SIGNED != 0) && w_in[DATA_W-1]}}, w_in};
    prod    = ifm_ext * w_ext;
    prod_ext = {ACC_W{(SIGNED != 0) && prod[2*DATA_W-1]}};
    prod_ext[2*DATA_W-1:0] = prod;
    cnt_inc = cnt + LEN_W'(1);
    beat_accept = (state == ST_ACC) && !abort && in_valid;
  end

`ifdef PE_SATURATE_EN
  logic [ACC_W-1:0] sum_raw;
  logic             add_ovf;

  // Signed overflow: both addends share a sign that the result lost.
  // Unsigned overflow: the sum wrapped below the old accumulator value.
  // Clamp toward the direction of the overflow.
  always_comb begin
    sum_raw = acc + prod_ext;
    if (SIGNED != 0) begin
      add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                (sum_raw[ACC_W-1] != acc[ACC_W-1]);
    end else begin
      add_ovf = (sum_raw < acc);
    end
    acc_next = sum_raw;
    if (add_ovf) begin
      if (SIGNED == 0) begin
        acc_next = {ACC_W{1'b1}};
      end else if (acc[ACC_W-1]) begin
        acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        acc_next = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end

  logic ovf_q;

  // Sticky overflow: cleared by an accepted start or reset, set by any
  // clamped addition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      ovf_q <= 1'b0;
    end else if (beat_accept && add_ovf) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  // Wrapping accumulation; overflow is not tracked.
  always_comb begin
    acc_next = acc + prod_ext;
  end

  assign ovf = 1'b0;
`endif

  // Control FSM. The start cycle only latches len and clears the datapath,
  // so a beat presented alongside start is not accumulated. A zero-length
  // request goes straight to DONE to emit a zero result. Abort wins over a
  // coincident beat; start while busy is simply not looked at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      len_q <= '0;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q <= len;
            cnt   <= '0;
            acc   <= '0;
            state <= (len != '0) ? ST_ACC : ST_DONE;
          end
        end
        ST_ACC: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (in_valid) begin
            acc <= acc_next;
            cnt <= cnt_inc;
            if (cnt_inc == len_q) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The result is the accumulator itself, so it holds until the next
  // accepted start clears it; the strobe is simply the DONE state.
  assign psum_out   = acc;
  assign psum_valid = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_pe_mac.sv
module tb_pe_mac;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              abort;
  logic [DATA_W-1:0] ifm_in;
  logic [DATA_W-1:0] w_in;
  logic              in_valid;
  logic [DATA_W-1:0] ifm_pass;
  logic [DATA_W-1:0] w_pass;
  logic              pass_valid;
  logic [ACC_W-1:0]  psum_out;
  logic              psum_valid;
  logic              busy;
  logic              ovf;

  int checks   = 0;
  int failures = 0;

  logic [ACC_W-1:0] exp_psum[$];
  logic             exp_ovf[$];

  logic [DATA_W-1:0] exp_ifm_pass;
  logic [DATA_W-1:0] exp_w_pass;
  logic              exp_pass_valid;

  logic [DATA_W-1:0] va[4];
  logic [DATA_W-1:0] vb[4];

  pe_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .LEN_W (LEN_W),
    .SIGNED(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .ifm_in    (ifm_in),
    .w_in      (w_in),
    .in_valid  (in_valid),
    .ifm_pass  (ifm_pass),
    .w_pass    (w_pass),
    .pass_valid(pass_valid),
    .psum_out  (psum_out),
    .psum_valid(psum_valid),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the DUT take the edge, return just after it.
  task automatic applyStimulus(input logic s, input logic [LEN_W-1:0] l,
                               input logic ab, input logic v,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    start    = s;
    len      = l;
    abort    = ab;
    in_valid = v;
    ifm_in   = a;
    w_in     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpected(input logic [ACC_W-1:0] p, input logic o);
    exp_psum.push_back(p);
    exp_ovf.push_back(o);
  endtask

  // Reference for the forward path: the previous cycle's inputs.
  always @(posedge clk) begin
    if (rst) begin
      exp_ifm_pass   <= '0;
      exp_w_pass     <= '0;
      exp_pass_valid <= 1'b0;
    end else begin
      exp_ifm_pass   <= ifm_in;
      exp_w_pass     <= w_in;
      exp_pass_valid <= in_valid;
    end
  end

  // Monitor: pops the scoreboard on every result strobe and checks the
  // forward path every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("ifm_pass", 32'(ifm_pass), 32'(exp_ifm_pass));
      checkOutput("w_pass", 32'(w_pass), 32'(exp_w_pass));
      checkOutput("pass_valid", 32'(pass_valid), 32'(exp_pass_valid));
      if (psum_valid) begin
        if (exp_psum.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_psum_valid: got psum_out=0x%0h, expected no strobe at %0t",
                   psum_out, $time);
        end else begin
          checkOutput("sb_psum", 32'(psum_out), 32'(exp_psum.pop_front()));
          checkOutput("sb_ovf", 32'(ovf), 32'(exp_ovf.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; ifm_in = '0; w_in = '0;

    // Reset state
    #2;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_psum_valid", 32'(psum_valid), 0);
    checkOutput("rst_psum_out", 32'(psum_out), 0);
    checkOutput("rst_ovf", 32'(ovf), 0);
    checkOutput("rst_pass_valid", 32'(pass_valid), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Back-to-back beats 1*5+2*6+3*7+4*8 = 70; the start-cycle beat is ignored
    va = '{8'd1, 8'd2, 8'd3, 8'd4};
    vb = '{8'd5, 8'd6, 8'd7, 8'd8};
    pushExpected(16'd70, 1'b0);
    applyStimulus(1, 8'd4, 0, 1, 8'd100, 8'd100);
    for (int i = 0; i < 4; i++) begin
      checkOutput("no_early_valid", 32'(psum_valid), 0);
      applyStimulus(0, 0, 0, 1, va[i], vb[i]);
    end
    checkOutput("valid_after_k", 32'(psum_valid), 1);
    checkOutput("psum_70", 32'(psum_out), 32'd70);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("valid_one_cycle", 32'(psum_valid), 0);
    checkOutput("idle_after_done", 32'(busy), 0);
    checkOutput("psum_hold", 32'(psum_out), 32'd70);

    // Same data with bubbles in between
    pushExpected(16'd70, 1'b0);
    applyStimulus(1, 8'd4, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("bubble_busy", 32'(busy), 1);
      applyStimulus(0, 0, 0, 1, va[i], vb[i]);
      if (i < 3) begin
        checkOutput("bubble_no_valid", 32'(psum_valid), 0);
        checkOutput("bubble_busy", 32'(busy), 1);
        applyStimulus(0, 0, 0, 0, 8'h55, 8'h55);
        checkOutput("bubble_no_valid", 32'(psum_valid), 0);
      end
    end
    checkOutput("bubble_valid", 32'(psum_valid), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Zero-length request
    pushExpected(16'd0, 1'b0);
    applyStimulus(1, 8'd0, 0, 1, 8'd9, 8'd9);
    checkOutput("len0_valid", 32'(psum_valid), 1);
    checkOutput("len0_psum", 32'(psum_out), 0);
    applyStimulus(0, 0, 0, 1, 8'd9, 8'd9);
    applyStimulus(0, 0, 0, 1, 8'd9, 8'd9);
    checkOutput("len0_idle", 32'(busy), 0);
    checkOutput("len0_psum_hold", 32'(psum_out), 0);

    // Three products of (-128)*(-128) = 16384 in a 16-bit accumulator
`ifdef PE_SATURATE_EN
    pushExpected(16'h7FFF, 1'b1);
`else
    pushExpected(16'hC000, 1'b0);
`endif
    applyStimulus(1, 8'd3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 8'h80, 8'h80);
    checkOutput("ovf_case_valid", 32'(psum_valid), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Negative products: (-3)*5 + 2*3 = -9; start clears ovf
    pushExpected(16'hFFF7, 1'b0);
    applyStimulus(1, 8'd2, 0, 0, 0, 0);
    checkOutput("ovf_cleared", 32'(ovf), 0);
    applyStimulus(0, 0, 0, 1, 8'hFD, 8'h05);
    applyStimulus(0, 0, 0, 1, 8'h02, 8'h03);
    checkOutput("neg_valid", 32'(psum_valid), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Forward path in IDLE
    applyStimulus(0, 0, 0, 1, 8'hA5, 8'h3C);
    checkOutput("fwd_ifm", 32'(ifm_pass), 32'hA5);
    checkOutput("fwd_w", 32'(w_pass), 32'h3C);
    checkOutput("fwd_valid", 32'(pass_valid), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset after two of four beats
    applyStimulus(1, 8'd4, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 8'd3, 8'd3);
    applyStimulus(0, 0, 0, 1, 8'd4, 8'd4);
    in_valid = 1'b0; ifm_in = '0; w_in = '0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_psum", 32'(psum_out), 0);
    checkOutput("midrst_psum_valid", 32'(psum_valid), 0);
    checkOutput("midrst_pass_valid", 32'(pass_valid), 0);
    checkOutput("midrst_ifm_pass", 32'(ifm_pass), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 8'd5, 8'd5);
    checkOutput("midrst_stays_idle", 32'(busy), 0);

    // Abort after two beats, coincident beat is dropped
    applyStimulus(1, 8'd4, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 8'd3, 8'd3);
    applyStimulus(0, 0, 0, 1, 8'd4, 8'd4);
    applyStimulus(0, 0, 1, 1, 8'd7, 8'd7);
    checkOutput("abort_idle", 32'(busy), 0);
    checkOutput("abort_no_valid", 32'(psum_valid), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 8'd7, 8'd7);

    // Start during ACC ignored: len 2 honoured, 3*4 + 5*6 = 42
    pushExpected(16'd42, 1'b0);
    applyStimulus(1, 8'd2, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 8'd3, 8'd4);
    applyStimulus(1, 8'd5, 0, 1, 8'd5, 8'd6);
    checkOutput("busy_start_valid", 32'(psum_valid), 1);
    checkOutput("busy_start_psum", 32'(psum_out), 32'd42);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("busy_start_idle", 32'(busy), 0);

    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("scoreboard_drained", 32'(exp_psum.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/pe_mac.md
PE_MAC -- requirements
Module: pe_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of ifm and weight operands.
REQ-002 SHALL have parameter ACC_W, default 32, meaning accumulator and psum width (ACC_W >= 2*DATA_W).
REQ-003 SHALL have parameter LEN_W, default 8, meaning width of the MAC-count input.
REQ-004 SHALL have parameter SIGNED, default 1, meaning 1 = two's-complement operands, 0 = unsigned.
REQ-005 SHALL have ports: clk  in  1  sole clock, all state updates on posedge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  single-cycle request to begin one accumulation.
REQ-008 len  in  LEN_W  number of MAC beats K for this accumulation, sampled on start.
REQ-009 abort  in  1  cancel the current accumulation without output.
REQ-010 ifm_in  in  DATA_W  input feature-map operand; w_in  in  DATA_W  weight operand.
REQ-011 in_valid  in  1  qualifies ifm_in/w_in in the current cycle.
REQ-012 ifm_pass  out  DATA_W, w_pass  out  DATA_W, pass_valid  out  1  registered forward copies for the systolic neighbour.
REQ-013 psum_out  out  ACC_W  accumulated result; psum_valid  out  1  result strobe.
REQ-014 busy  out  1  high while in ACC or DONE; ovf  out  1  sticky overflow flag.

Function
REQ-015 SHALL forward ifm_in, w_in, in_valid to ifm_pass, w_pass, pass_valid with exactly 1-cycle latency in every state.
REQ-016 SHALL implement states IDLE, ACC, DONE; busy = (state != IDLE).
REQ-017 IDLE: start=1 SHALL latch len, clear accumulator, beat counter and ovf; next state ACC if len != 0, else DONE.
REQ-018 The beat in the same cycle as start SHALL NOT be accumulated; accumulation begins the following cycle.
REQ-019 ACC: each in_valid=1 cycle SHALL add ifm_in*w_in to the accumulator and increment the counter; in_valid=0 cycles SHALL hold state.
REQ-020 Product SHALL be 2*DATA_W wide, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W before addition.
REQ-021 ACC: the edge that accepts beat K SHALL move to DONE.
REQ-022 DONE: psum_valid SHALL be 1 for exactly one cycle, immediately after the edge accepting beat K; next state IDLE.
REQ-023 psum_out SHALL equal the accumulator and hold its value until the next accepted start.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort=1 in ACC SHALL return to IDLE next edge, no psum_valid; abort has priority over in_valid; ignored in IDLE/DONE.
REQ-026 Without saturation the accumulator SHALL wrap modulo 2^ACC_W and ovf SHALL stay 0.

Reset
REQ-027 rst=1 SHALL immediately, without clock, force state IDLE and all outputs and internal registers to 0.
REQ-028 Reset mid-accumulation SHALL discard the partial sum; no psum_valid SHALL follow.

Configuration
REQ-029 Macro PE_SATURATE_EN defined: each addition overflowing the ACC_W range SHALL clamp to max/min representable value (unsigned: 2^ACC_W-1) and set ovf, which stays 1 until next accepted start or reset.
REQ-030 PE_SATURATE_EN undefined: wrap per REQ-026, ovf tied 0.

Verification
REQ-031 SIGNED=1, len=4, ifm {1,2,3,4}, w {5,6,7,8} on consecutive cycles -> psum_valid one cycle after 4th beat, psum_out=70.
REQ-032 Same data with in_valid=0 bubbles between beats -> psum_out=70, busy held high throughout, no early psum_valid.
REQ-033 len=0 start -> psum_valid the cycle after start, psum_out=0; in_valid beats ignored.
REQ-034 ACC_W=16, SIGNED=1, len=3, ifm=w=0x80 (-128) -> undefined macro: psum_out=0xC000 (-16384), ovf=0; PE_SATURATE_EN: psum_out=0x7FFF, ovf=1.
REQ-035 ifm_in=0xA5, w_in=0x3C, in_valid=1 in any state -> ifm_pass=0xA5, w_pass=0x3C, pass_valid=1 next cycle.
REQ-036 rst pulse after 2 of 4 beats -> outputs 0 immediately, no psum_valid; abort after 2 beats -> IDLE, no psum_valid; start during ACC -> ignored, original len honoured.
